// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port arbiter and sequencer for the single-port data SRAM.
// Port m0 is the core load/store port, m1 a secondary master (DMA / loader).
// Every SRAM strobe and every gnt/rvalid comes straight from a flop.
// Optional feature: define DMEM_ARB_FIXED_PRIO_EN for fixed priority (m0 always
// wins a tie); left undefined, ties are resolved round-robin.
module dmem_arbiter #(
  parameter int ADDR_W  = 7,
  parameter int DATA_W  = 32,
  parameter int MEM_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              CEN,
  output logic              WEN,
  output logic [ADDR_W-1:0] A,
  output logic [DATA_W-1:0] D,
  output logic              OEN,
  input  logic [DATA_W-1:0] Q
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_e;

  state_e              state_q, state_d;
  logic                sel_q, sel_d;
  logic                we_q, we_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                cen_q, cen_d;
  logic                wen_q, wen_d;
  logic                oen_q, oen_d;
  logic [ADDR_W-1:0]   a_q, a_d;
  logic [DATA_W-1:0]   dout_q, dout_d;
  logic [1:0]          gnt_q, gnt_d;
  logic [1:0]          rvalid_q, rvalid_d;
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;
  logic                any_req;
  logic                pick;

  assign any_req = m0_req | m1_req;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  // Fixed priority: m0 wins whenever it requests, m1 only gets an idle bus.
  always_comb pick = ~m0_req;
`else
  logic last_q, last_d;

  // Round-robin: a lone request wins, a tie goes to the port not served last.
  always_comb begin
    if (m0_req && m1_req) pick = ~last_q;
    else                  pick = m1_req;
  end

  // Track the most recently selected port; starts at 1 so m0 wins the first tie.
  always_comb last_d = (state_q == IDLE && any_req) ? pick : last_q;

  // Last-served register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) last_q <= 1'b1;
    else        last_q <= last_d;
  end
`endif

  // Sequencer: selects in IDLE, strobes the SRAM for one ACCESS cycle, waits out
  // the read latency, then returns the data with a one-cycle rvalid.
  always_comb begin
    state_d  = state_q;
    sel_d    = sel_q;
    we_d     = we_q;
    cnt_d    = cnt_q;
    cen_d    = cen_q;
    wen_d    = wen_q;
    oen_d    = oen_q;
    a_d      = a_q;
    dout_d   = dout_q;
    gnt_d    = 2'b00;
    rvalid_d = 2'b00;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          sel_d        = pick;
          we_d         = pick ? m1_we : m0_we;
          a_d          = pick ? m1_addr : m0_addr;
          cen_d        = 1'b0;
          wen_d        = ~we_d;
          oen_d        = we_d;
          gnt_d[pick]  = 1'b1;
          if (we_d) dout_d = pick ? m1_wdata : m0_wdata;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        cen_d = 1'b1;
        wen_d = 1'b1;
        if (we_q) begin
          oen_d   = 1'b1;
          state_d = IDLE;
        end else begin
          oen_d   = 1'b0;
          cnt_d   = 3'(MEM_LAT - 1);
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (cnt_q == 3'd0) begin
          oen_d           = 1'b1;
          rvalid_d[sel_q] = 1'b1;
          if (sel_q) rdata1_d = Q;
          else       rdata0_d = Q;
          state_d         = RESP;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      sel_q    <= 1'b0;
      we_q     <= 1'b0;
      cnt_q    <= 3'd0;
      cen_q    <= 1'b1;
      wen_q    <= 1'b1;
      oen_q    <= 1'b1;
      a_q      <= '0;
      dout_q   <= '0;
      gnt_q    <= 2'b00;
      rvalid_q <= 2'b00;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      we_q     <= we_d;
      cnt_q    <= cnt_d;
      cen_q    <= cen_d;
      wen_q    <= wen_d;
      oen_q    <= oen_d;
      a_q      <= a_d;
      dout_q   <= dout_d;
      gnt_q    <= gnt_d;
      rvalid_q <= rvalid_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
    end
  end

  assign CEN       = cen_q;
  assign WEN       = wen_q;
  assign OEN       = oen_q;
  assign A         = a_q;
  assign D         = dout_q;
  assign m0_gnt    = gnt_q[0];
  assign m1_gnt    = gnt_q[1];
  assign m0_rvalid = rvalid_q[0];
  assign m1_rvalid = rvalid_q[1];
  assign m0_rdata  = rdata0_q;
  assign m1_rdata  = rdata1_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: drives two arbiter instances (SRAM latency 1 and 3) with
// directed and random traffic. A transaction-timeline model predicts every
// strobe, grant and response; a separate SRAM model supplies Q.
module tb_dmem_arbiter;
  localparam int AW = 7;
  localparam int DW = 32;

  logic clk = 1'b0;
  logic rst_n;

  logic          m_req    [2][2];
  logic          m_we     [2][2];
  logic [AW-1:0] m_addr   [2][2];
  logic [DW-1:0] m_wdata  [2][2];
  logic          m_gnt    [2][2];
  logic          m_rvalid [2][2];
  logic [DW-1:0] m_rdata  [2][2];
  logic          s_cen [2];
  logic          s_wen [2];
  logic          s_oen [2];
  logic [AW-1:0] s_a   [2];
  logic [DW-1:0] s_d   [2];
  logic [DW-1:0] s_q   [2];

  int errors = 0;
  int checks = 0;

  // Model state: one transaction record per instance plus a memory image.
  int            lat      [2];
  int            acc      [2];
  int            next_sel [2];
  int            nedge;
  int            mode;
  logic          msel  [2];
  logic          mwe   [2];
  logic [AW-1:0] maddr [2];
  logic [DW-1:0] mwdata[2];
  logic [DW-1:0] mrdv  [2];
  logic [DW-1:0] exp_rdata [2][2];
  logic [DW-1:0] mem_m [2][128];
`ifndef DMEM_ARB_FIXED_PRIO_EN
  logic          mlast [2];
`endif

  // SRAM behaviour seen by each instance.
  logic [DW-1:0] mem_s   [2][128];
  int            rd_left [2];
  logic [AW-1:0] rd_addr [2];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MEM_LAT(g == 0 ? 1 : 3)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .m0_req(m_req[g][0]), .m0_we(m_we[g][0]), .m0_addr(m_addr[g][0]), .m0_wdata(m_wdata[g][0]),
      .m0_gnt(m_gnt[g][0]), .m0_rvalid(m_rvalid[g][0]), .m0_rdata(m_rdata[g][0]),
      .m1_req(m_req[g][1]), .m1_we(m_we[g][1]), .m1_addr(m_addr[g][1]), .m1_wdata(m_wdata[g][1]),
      .m1_gnt(m_gnt[g][1]), .m1_rvalid(m_rvalid[g][1]), .m1_rdata(m_rdata[g][1]),
      .CEN(s_cen[g]), .WEN(s_wen[g]), .A(s_a[g]), .D(s_d[g]), .OEN(s_oen[g]), .Q(s_q[g])
    );
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input int d, input int p, input logic we,
                               input logic [AW-1:0] addr, input logic [DW-1:0] wdata);
    m_req[d][p]   = 1'b1;
    m_we[d][p]    = we;
    m_addr[d][p]  = addr;
    m_wdata[d][p] = wdata;
  endtask

  task automatic modelReset();
    for (int d = 0; d < 2; d++) begin
      acc[d]      = -100;
      next_sel[d] = 0;
      mwe[d]      = 1'b1;
      msel[d]     = 1'b0;
      exp_rdata[d][0] = '0;
      exp_rdata[d][1] = '0;
`ifndef DMEM_ARB_FIXED_PRIO_EN
      mlast[d]    = 1'b1;
`endif
    end
  endtask

  // At each rising edge: start a transaction if the instance is free and someone asks.
  task automatic modelEdge();
    for (int d = 0; d < 2; d++) begin
      logic p;
      if (rst_n && nedge >= next_sel[d] && (m_req[d][0] || m_req[d][1])) begin
`ifdef DMEM_ARB_FIXED_PRIO_EN
        p = m_req[d][0] ? 1'b0 : 1'b1;
`else
        if (m_req[d][0] && m_req[d][1]) p = ~mlast[d];
        else                            p = m_req[d][1];
        mlast[d] = p;
`endif
        acc[d]    = nedge;
        msel[d]   = p;
        mwe[d]    = m_we[d][p];
        maddr[d]  = m_addr[d][p];
        mwdata[d] = m_wdata[d][p];
        if (mwe[d]) begin
          mem_m[d][maddr[d]] = mwdata[d];
          next_sel[d] = nedge + 2;
        end else begin
          mrdv[d] = mem_m[d][maddr[d]];
          next_sel[d] = nedge + lat[d] + 3;
        end
      end
    end
  endtask

  // Requesters: drop req the cycle after gnt (mode 0/2), keep reading (mode 1),
  // or start/abandon requests at random (mode 2).
  task automatic driveAgents();
    for (int d = 0; d < 2; d++) begin
      for (int p = 0; p < 2; p++) begin
        if (m_req[d][p]) begin
          if (acc[d] == nedge - 1 && msel[d] == p) begin
            if (mode == 1) m_addr[d][p] = AW'($urandom);
            else           m_req[d][p] = 1'b0;
          end else if (mode == 2 && $urandom_range(0, 15) == 0) begin
            m_req[d][p] = 1'b0;
          end
        end else if (mode == 2 && $urandom_range(0, 2) == 0) begin
          applyStimulus(d, p, 1'($urandom), AW'($urandom), $urandom);
        end
      end
    end
  endtask

  task automatic checkCycle();
    for (int d = 0; d < 2; d++) begin
      bit    inacc, rdwin, rsp;
      string pre;
      pre   = $sformatf("dut%0d cyc%0d", d, nedge);
      inacc = (nedge == acc[d]);
      rdwin = !mwe[d] && nedge >= acc[d] && nedge <= acc[d] + lat[d];
      rsp   = !mwe[d] && nedge == acc[d] + lat[d] + 1;
      checkOutput({pre, " CEN"}, 32'(s_cen[d]), 32'(!inacc));
      checkOutput({pre, " OEN"}, 32'(s_oen[d]), 32'(!rdwin));
      for (int p = 0; p < 2; p++) begin
        if (rsp && msel[d] == p) exp_rdata[d][p] = mrdv[d];
        checkOutput($sformatf("%s m%0d_gnt", pre, p), 32'(m_gnt[d][p]), 32'(inacc && msel[d] == p));
        checkOutput($sformatf("%s m%0d_rvalid", pre, p), 32'(m_rvalid[d][p]), 32'(rsp && msel[d] == p));
        checkOutput($sformatf("%s m%0d_rdata", pre, p), m_rdata[d][p], exp_rdata[d][p]);
      end
      if (inacc) begin
        checkOutput({pre, " A"}, 32'(s_a[d]), 32'(maddr[d]));
        checkOutput({pre, " WEN"}, 32'(s_wen[d]), 32'(!mwe[d]));
        if (mwe[d]) checkOutput({pre, " D"}, s_d[d], mwdata[d]);
      end
    end
  endtask

  // SRAM: writes land on the access cycle, read data is valid only on the cycle
  // in which it must be sampled; every other cycle Q carries noise.
  task automatic sramNegedge();
    for (int d = 0; d < 2; d++) begin
      if (!s_cen[d] && !s_wen[d]) mem_s[d][s_a[d]] = s_d[d];
      if (!s_cen[d] && s_wen[d]) begin
        rd_left[d] = lat[d];
        rd_addr[d] = s_a[d];
        s_q[d]     = $urandom;
      end else if (rd_left[d] > 0) begin
        rd_left[d]--;
        s_q[d] = (rd_left[d] == 0) ? mem_s[d][rd_addr[d]] : $urandom;
      end else begin
        s_q[d] = $urandom;
      end
    end
  endtask

  task automatic stepCycle();
    @(posedge clk);
    nedge++;
    modelEdge();
    #1;
    driveAgents();
    @(negedge clk);
    checkCycle();
    sramNegedge();
  endtask

  task automatic checkResetValues(input string tag);
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("%s dut%0d CEN", tag, d), 32'(s_cen[d]), 32'd1);
      checkOutput($sformatf("%s dut%0d WEN", tag, d), 32'(s_wen[d]), 32'd1);
      checkOutput($sformatf("%s dut%0d OEN", tag, d), 32'(s_oen[d]), 32'd1);
      checkOutput($sformatf("%s dut%0d A", tag, d), 32'(s_a[d]), 32'd0);
      checkOutput($sformatf("%s dut%0d D", tag, d), s_d[d], 32'd0);
      for (int p = 0; p < 2; p++) begin
        checkOutput($sformatf("%s dut%0d m%0d_gnt", tag, d, p), 32'(m_gnt[d][p]), 32'd0);
        checkOutput($sformatf("%s dut%0d m%0d_rvalid", tag, d, p), 32'(m_rvalid[d][p]), 32'd0);
        checkOutput($sformatf("%s dut%0d m%0d_rdata", tag, d, p), m_rdata[d][p], 32'd0);
      end
    end
  endtask

  initial begin
    rst_n  = 1'b0;
    nedge  = -1;
    mode   = 0;
    lat[0] = 1;
    lat[1] = 3;
    for (int d = 0; d < 2; d++) begin
      rd_left[d] = 0;
      rd_addr[d] = '0;
      s_q[d]     = '0;
      for (int p = 0; p < 2; p++) begin
        m_req[d][p] = 1'b0;
        m_we[d][p] = 1'b0;
        m_addr[d][p] = '0;
        m_wdata[d][p] = '0;
      end
      for (int i = 0; i < 128; i++) begin
        mem_s[d][i] = $urandom;
        mem_m[d][i] = mem_s[d][i];
      end
    end
    modelReset();

    // Power-on reset.
    repeat (3) stepCycle();
    checkResetValues("por");
    rst_n = 1'b1;
    repeat (2) stepCycle();

    // m0 write 0x05 <= DEADBEEF, then read it back.
    for (int d = 0; d < 2; d++) applyStimulus(d, 0, 1'b1, 7'h05, 32'hDEADBEEF);
    repeat (4) stepCycle();
    for (int d = 0; d < 2; d++) applyStimulus(d, 0, 1'b0, 7'h05, 32'h0);
    repeat (8) stepCycle();
    for (int d = 0; d < 2; d++)
      checkOutput($sformatf("readback dut%0d", d), m_rdata[d][0], 32'hDEADBEEF);

    // Both ports hold read requests continuously.
    mode = 1;
    for (int d = 0; d < 2; d++) begin
      applyStimulus(d, 0, 1'b0, 7'h10, 32'h0);
      applyStimulus(d, 1, 1'b0, 7'h20, 32'h0);
    end
    repeat (130) stepCycle();
    mode = 0;
    repeat (20) stepCycle();

    // m1 read of the top address.
    for (int d = 0; d < 2; d++) applyStimulus(d, 1, 1'b0, 7'h7F, 32'h0);
    repeat (8) stepCycle();

    // Reset asserted during the WAIT phase of an m0 read.
    for (int d = 0; d < 2; d++) applyStimulus(d, 0, 1'b0, 7'h05, 32'h0);
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      if (acc[0] >= 0 && nedge == acc[0] + 1) break;
    end
    checkOutput("reach wait before reset", 32'(nedge == acc[0] + 1), 32'd1);
    #1 rst_n = 1'b0;
    #1;
    checkResetValues("midreset");
    modelReset();
    repeat (2) stepCycle();
    rst_n = 1'b1;
    repeat (6) stepCycle();
    for (int d = 0; d < 2; d++) applyStimulus(d, 0, 1'b0, 7'h05, 32'h0);
    repeat (8) stepCycle();

    // Random traffic, then drain.
    mode = 2;
    repeat (500) stepCycle();
    mode = 0;
    repeat (30) stepCycle();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
